// File: rtl/regfile_pkg.sv
// regfile_pkg: shared address-width helper, register typedefs and the x0 address constant.
package regfile_pkg;
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  typedef logic [addr_w(NREGS_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits (claim beats clear, x0 never busy) and registered busy count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NWRITE = 1,
  localparam int AW = addr_w(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NWRITE-1:0]          i_we,
  input  logic [NWRITE-1:0][AW-1:0]  i_wa,
  input  logic                       i_claim_en,
  input  logic [AW-1:0]              i_claim_addr,
  output logic [NREGS-1:0]           o_busy,
  output logic [AW:0]                o_nbusy
);
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_nbusy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      w_cnt;
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWRITE; j++)
      if (i_we[j]) w_busy_nxt[i_wa[j]] = 1'b0;
    if (i_claim_en) w_busy_nxt[i_claim_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    w_cnt = '0;
    for (int k = 0; k < NREGS; k++) w_cnt = w_cnt + (AW+1)'(w_busy_nxt[k]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_busy  <= '0;
      r_nbusy <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_nbusy <= w_cnt;
    end
  assign o_busy  = r_busy;
  assign o_nbusy = r_nbusy;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired to zero, highest-port-wins writes,
// optional same-cycle write-to-read forwarding and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int NWRITE = 1,
  parameter int BYPASS = 1,
  localparam int AW = addr_w(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREAD-1:0][AW-1:0]     ra,
  output logic [NREAD-1:0][XLEN-1:0]   rd,
  output logic [NREAD-1:0]             rd_busy,
  input  logic [NWRITE-1:0]            we,
  input  logic [NWRITE-1:0][AW-1:0]    wa,
  input  logic [NWRITE-1:0][XLEN-1:0]  wd,
  input  logic                         claim_en,
  input  logic [AW-1:0]                claim_addr,
  output logic [AW:0]                  nbusy
);
  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] w_busy;
  // later ports overwrite earlier ones, so the highest-index port wins a collision
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < NREGS; k++) r_mem[k] <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++)
        if (we[j] && wa[j] != AW'(REG_ZERO)) r_mem[wa[j]] <= wd[j];
    end
  regfile_scoreboard #(.NREGS(NREGS), .NWRITE(NWRITE)) u_sb (
    .clk(clk), .rst(rst), .i_we(we), .i_wa(wa), .i_claim_en(claim_en),
    .i_claim_addr(claim_addr), .o_busy(w_busy), .o_nbusy(nbusy)
  );
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic            w_hit;
    logic [XLEN-1:0] w_fwd;
    // forwarding is suppressed during reset so reads stay zero while rst is high
    always_comb begin
      w_hit = 1'b0;
      w_fwd = r_mem[ra[i]];
      for (int j = 0; j < NWRITE; j++)
        if (BYPASS != 0 && !rst && we[j] && wa[j] == ra[i] && ra[i] != AW'(REG_ZERO)) begin
          w_hit = 1'b1;
          w_fwd = wd[j];
        end
    end
    assign rd[i]      = w_fwd;
    assign rd_busy[i] = w_busy[ra[i]] & ~w_hit;
  end
endmodule
